// File: rtl/opb_reg_arbiter_if.sv
// ============================================================================
// opb_reg_arbiter_if
// ----------------------------------------------------------------------------
// Bus bundle for the OPB scratch-pad/register slave arbiter: two requester
// ports (M0 = host bridge, M1 = debug/JTAG bridge) plus the shared slave port.
//
// Modports:
//   slave  - the arbiter's view: takes requests and SP_DO, drives ACK/RDATA,
//            the slave strobes, address, write data and GNT.
//   master - the surrounding system's view (requesters and the slave memory).
//
// Signals:
//   Mx_REQ   level request, held until Mx_ACK
//   Mx_WR    1 = write, 0 = read
//   Mx_LOCK  keep priority for the next access (OPB_ARB_LOCK_EN builds only)
//   Mx_ADDR  access address
//   Mx_WDATA write data
//   Mx_ACK   one-cycle completion pulse
//   Mx_RDATA read data, valid in the ACK cycle, held until the next read ACK
//   OPB_ADDR registered slave address
//   SP_DI    registered slave write data
//   SP_RE    slave read strobe
//   SP_WE    slave write strobe
//   SP_DO    slave read data
//   GNT      one-hot owner (bit0 = M0), 0 when idle
// ============================================================================
interface opb_reg_arbiter_if;
    logic        M0_REQ;
    logic        M0_WR;
    logic        M0_LOCK;
    logic [31:0] M0_ADDR;
    logic [31:0] M0_WDATA;
    logic        M0_ACK;
    logic [31:0] M0_RDATA;

    logic        M1_REQ;
    logic        M1_WR;
    logic        M1_LOCK;
    logic [31:0] M1_ADDR;
    logic [31:0] M1_WDATA;
    logic        M1_ACK;
    logic [31:0] M1_RDATA;

    logic [31:0] OPB_ADDR;
    logic [31:0] SP_DI;
    logic        SP_RE;
    logic        SP_WE;
    logic [31:0] SP_DO;
    logic [1:0]  GNT;

    modport slave (
        input  M0_REQ, M0_WR, M0_LOCK, M0_ADDR, M0_WDATA,
        input  M1_REQ, M1_WR, M1_LOCK, M1_ADDR, M1_WDATA,
        input  SP_DO,
        output M0_ACK, M0_RDATA, M1_ACK, M1_RDATA,
        output OPB_ADDR, SP_DI, SP_RE, SP_WE, GNT
    );

    modport master (
        output M0_REQ, M0_WR, M0_LOCK, M0_ADDR, M0_WDATA,
        output M1_REQ, M1_WR, M1_LOCK, M1_ADDR, M1_WDATA,
        output SP_DO,
        input  M0_ACK, M0_RDATA, M1_ACK, M1_RDATA,
        input  OPB_ADDR, SP_DI, SP_RE, SP_WE, GNT
    );
endinterface

// File: rtl/opb_reg_arbiter.sv
// ============================================================================
// opb_reg_arbiter
// ----------------------------------------------------------------------------
// Two-requester arbiter/sequencer for the OPB scratch-pad/register slave.
// Each granted request becomes exactly one single-cycle SP_RE or SP_WE strobe;
// read data is captured READ_LAT cycles after the strobe and returned with a
// one-cycle ACK. Ties go to the requester not served last (M0 wins the first).
//
// Parameters:
//   READ_LAT  cycles from SP_RE strobe to valid SP_DO (legal 1..15)
//
// Ports:
//   OPB_CLK   clock, rising edge
//   OPB_RST   asynchronous active-high reset
//   bus       opb_reg_arbiter_if.slave (requester ports + slave port + GNT)
//
// Optional feature macro: OPB_ARB_LOCK_EN
//   defined     - owner's LOCK high in its ACK cycle keeps the last-served
//                 pointer, so the owner also wins the next tie
//   not defined - LOCK inputs are ignored, pure round-robin
//
// Timing (REQ sampled in cycle 0):
//   write: SP_WE cycle 1, ACK cycle 2
//   read : SP_RE cycle 1, ACK cycle 2+READ_LAT
// ============================================================================
module opb_reg_arbiter #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic               OPB_CLK,
    input  logic               OPB_RST,
    opb_reg_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);

    state_t      r_state;
    logic        r_owner;      // 0 = M0, 1 = M1
    logic        r_last_m1;    // last served requester, 1 = M1
    logic        r_wr;
    logic [3:0]  r_cnt;
    logic [1:0]  r_gnt;
    logic [31:0] r_opb_addr;
    logic [31:0] r_sp_di;
    logic        r_sp_re;
    logic        r_sp_we;
    logic        r_m0_ack;
    logic        r_m1_ack;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_any_req;
    logic        w_pick_m1;
    logic        w_sel_wr;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
`ifdef OPB_ARB_LOCK_EN
    logic        w_owner_lock;
`endif

    // M1 wins when it is the only requester, or on a tie when M0 was served last.
    always_comb begin
        w_any_req   = bus.M0_REQ | bus.M1_REQ;
        w_pick_m1   = bus.M1_REQ & (~bus.M0_REQ | ~r_last_m1);
        w_sel_wr    = w_pick_m1 ? bus.M1_WR    : bus.M0_WR;
        w_sel_addr  = w_pick_m1 ? bus.M1_ADDR  : bus.M0_ADDR;
        w_sel_wdata = w_pick_m1 ? bus.M1_WDATA : bus.M0_WDATA;
`ifdef OPB_ARB_LOCK_EN
        w_owner_lock = r_owner ? bus.M1_LOCK : bus.M0_LOCK;
`endif
    end

    // The latched address/data live directly in the registered OPB_ADDR/SP_DI
    // outputs: they are loaded on the grant edge so they are valid together
    // with the strobe in the STROBE cycle, and simply hold afterwards.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_last_m1  <= 1'b1;
            r_wr       <= 1'b0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_opb_addr <= '0;
            r_sp_di    <= '0;
            r_sp_re    <= 1'b0;
            r_sp_we    <= 1'b0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            // Strobes and ACKs are single-cycle pulses.
            r_sp_re  <= 1'b0;
            r_sp_we  <= 1'b0;
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner    <= w_pick_m1;
                        r_gnt      <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_wr       <= w_sel_wr;
                        r_opb_addr <= w_sel_addr;
                        if (w_sel_wr) begin
                            r_sp_di <= w_sel_wdata;
                        end
                        r_sp_we    <= w_sel_wr;
                        r_sp_re    <= ~w_sel_wr;
                        r_state    <= S_STROBE;
                    end
                end

                S_STROBE: begin
                    if (r_wr) begin
                        r_m0_ack <= ~r_owner;
                        r_m1_ack <= r_owner;
                        r_state  <= S_ACK;
                    end else begin
                        r_cnt    <= LAT_LAST;
                        r_state  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_owner) begin
                            r_m1_rdata <= bus.SP_DO;
                            r_m1_ack   <= 1'b1;
                        end else begin
                            r_m0_rdata <= bus.SP_DO;
                            r_m0_ack   <= 1'b1;
                        end
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_ACK: begin
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
`ifdef OPB_ARB_LOCK_EN
                    if (!w_owner_lock) begin
                        r_last_m1 <= r_owner;
                    end
`else
                    r_last_m1 <= r_owner;
`endif
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.GNT      = r_gnt;
    assign bus.OPB_ADDR = r_opb_addr;
    assign bus.SP_DI    = r_sp_di;
    assign bus.SP_RE    = r_sp_re;
    assign bus.SP_WE    = r_sp_we;
    assign bus.M0_ACK   = r_m0_ack;
    assign bus.M1_ACK   = r_m1_ack;
    assign bus.M0_RDATA = r_m0_rdata;
    assign bus.M1_RDATA = r_m1_rdata;

endmodule

// File: tb/tb_opb_reg_arbiter.sv
// ============================================================================
// tb_opb_reg_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for opb_reg_arbiter. u_dut runs READ_LAT = 1 and is
// checked through a scoreboard; u_dut3 runs READ_LAT = 3 for the latency case.
// Each DUT has a small behavioural slave memory that only presents valid
// SP_DO in the exact cycle READ_LAT after SP_RE and garbage otherwise.
// ============================================================================
module tb_opb_reg_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    opb_reg_arbiter_if bus ();
    opb_reg_arbiter_if bus3 ();

    opb_reg_arbiter #(.READ_LAT(1)) u_dut (
        .OPB_CLK (clk),
        .OPB_RST (rst),
        .bus     (bus)
    );

    opb_reg_arbiter #(.READ_LAT(3)) u_dut3 (
        .OPB_CLK (clk),
        .OPB_RST (rst),
        .bus     (bus3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- slave memory models ----------------
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    int          cd1 = 0;
    int          cd3 = 0;
    logic [3:0]  ra1;
    logic [3:0]  ra3;

    always @(posedge clk) begin
        if (bus.SP_WE) mem1[bus.OPB_ADDR[3:0]] = bus.SP_DI;
        if (bus.SP_RE) begin cd1 = 1; ra1 = bus.OPB_ADDR[3:0]; end
        bus.SP_DO <= (cd1 == 1) ? mem1[ra1] : (32'hBAD00000 ^ 32'(cyc));
        if (cd1 != 0) cd1--;
    end

    always @(posedge clk) begin
        if (bus3.SP_WE) mem3[bus3.OPB_ADDR[3:0]] = bus3.SP_DI;
        if (bus3.SP_RE) begin cd3 = 3; ra3 = bus3.OPB_ADDR[3:0]; end
        bus3.SP_DO <= (cd3 == 1) ? mem3[ra3] : (32'hBAD00000 ^ 32'(cyc));
        if (cd3 != 0) cd3--;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          t_req;
        int          lat;     // expected ACK cycle offset, -1 = not checked
        int          nstb;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] exp_rd [2];

    function automatic void sb_push(input bit m, input bit wr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] rdata,
                                    input int t_req, input int lat);
        exp_t e;
        e.m = m; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        e.t_req = t_req; e.lat = lat; e.nstb = 0;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.SP_RE || bus.SP_WE) begin
                check32("strobe_excl", 32'(bus.SP_RE & bus.SP_WE), 32'd0);
                if (sb.size() == 0) begin
                    check32("spurious_strobe", 32'({bus.SP_RE, bus.SP_WE}), 32'd0);
                end else begin
                    sb[0].nstb++;
                    check32("strobe_kind", 32'(bus.SP_WE), 32'(sb[0].wr));
                    check32("opb_addr", bus.OPB_ADDR, sb[0].addr);
                    if (sb[0].wr) check32("sp_di", bus.SP_DI, sb[0].wdata);
                    if (sb[0].lat >= 0) check32("strobe_cycle", 32'(cyc - sb[0].t_req), 32'd1);
                    check32("gnt_strobe", 32'(bus.GNT), sb[0].m ? 32'd2 : 32'd1);
                end
            end
            if (bus.M0_ACK || bus.M1_ACK) begin
                if (sb.size() == 0) begin
                    check32("spurious_ack", 32'({bus.M1_ACK, bus.M0_ACK}), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check32("ack_owner", 32'({bus.M1_ACK, bus.M0_ACK}), mon_e.m ? 32'd2 : 32'd1);
                    check32("gnt_ack", 32'(bus.GNT), mon_e.m ? 32'd2 : 32'd1);
                    check32("strobe_count", 32'(mon_e.nstb), 32'd1);
                    if (mon_e.lat >= 0) check32("ack_cycle", 32'(cyc - mon_e.t_req), 32'(mon_e.lat));
                    if (!mon_e.wr) exp_rd[mon_e.m] = mon_e.rdata;
                    check32("m0_rdata", bus.M0_RDATA, exp_rd[0]);
                    check32("m1_rdata", bus.M1_RDATA, exp_rd[1]);
                end
            end
        end
    end

    // ---------------- requester driver ----------------
    task automatic access(input bit m, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int lat, input bit push);
        int  n;
        logic ack;
        @(negedge clk);
        if (m) begin
            bus.M1_REQ = 1'b1; bus.M1_WR = wr; bus.M1_ADDR = addr; bus.M1_WDATA = wdata;
        end else begin
            bus.M0_REQ = 1'b1; bus.M0_WR = wr; bus.M0_ADDR = addr; bus.M0_WDATA = wdata;
        end
        if (push) sb_push(m, wr, addr, wdata, rdata, cyc, lat);
        n   = 0;
        ack = m ? bus.M1_ACK : bus.M0_ACK;
        while (!ack && n < 60) begin
            @(negedge clk);
            n++;
            ack = m ? bus.M1_ACK : bus.M0_ACK;
        end
        if (n >= 60) check32(m ? "m1_ack_timeout" : "m0_ack_timeout", 32'(ack), 32'd1);
        if (m) bus.M1_REQ = 1'b0; else bus.M0_REQ = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check32("rst_gnt",      32'(bus.GNT),    32'd0);
        check32("rst_sp_re",    32'(bus.SP_RE),  32'd0);
        check32("rst_sp_we",    32'(bus.SP_WE),  32'd0);
        check32("rst_m0_ack",   32'(bus.M0_ACK), 32'd0);
        check32("rst_m1_ack",   32'(bus.M1_ACK), 32'd0);
        check32("rst_opb_addr", bus.OPB_ADDR,    32'd0);
        check32("rst_sp_di",    bus.SP_DI,       32'd0);
        check32("rst_m0_rdata", bus.M0_RDATA,    32'd0);
        check32("rst_m1_rdata", bus.M1_RDATA,    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 32'h0; mem3[i] = 32'h0;
        end
        mem1[0] = 32'h12345678; mem1[1] = 32'h00000050; mem1[3] = 32'hCAFEBEEF;
        mem3[3] = 32'hCAFEBEEF;
        exp_rd[0] = '0; exp_rd[1] = '0;

        rst = 1'b1;
        bus.M0_REQ = 0; bus.M0_WR = 0; bus.M0_LOCK = 0; bus.M0_ADDR = '0; bus.M0_WDATA = '0;
        bus.M1_REQ = 0; bus.M1_WR = 0; bus.M1_LOCK = 0; bus.M1_ADDR = '0; bus.M1_WDATA = '0;
        bus3.M0_REQ = 0; bus3.M0_WR = 0; bus3.M0_LOCK = 0; bus3.M0_ADDR = '0; bus3.M0_WDATA = '0;
        bus3.M1_REQ = 0; bus3.M1_WR = 0; bus3.M1_LOCK = 0; bus3.M1_ADDR = '0; bus3.M1_WDATA = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // 1: M0 read of 0x3
        access(1'b0, 1'b0, 32'h3, 32'h0, 32'hCAFEBEEF, 3, 1'b1);

        // 2: M1 write then read of 0x3, M0_RDATA must stay
        access(1'b1, 1'b1, 32'h3, 32'h5A5A0001, 32'h0, 2, 1'b1);
        access(1'b1, 1'b0, 32'h3, 32'h0, 32'h5A5A0001, 3, 1'b1);

        // 3: contention, grants alternate M0, M1, M0, M1
        sb_push(1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678, 0, -1);
        sb_push(1'b1, 1'b0, 32'h1, 32'h0, 32'h00000050, 0, -1);
        sb_push(1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678, 0, -1);
        sb_push(1'b1, 1'b0, 32'h1, 32'h0, 32'h00000050, 0, -1);
        fork
            begin
                access(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, -1, 1'b0);
                access(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, -1, 1'b0);
            end
            begin
                access(1'b1, 1'b0, 32'h1, 32'h0, 32'h0, -1, 1'b0);
                access(1'b1, 1'b0, 32'h1, 32'h0, 32'h0, -1, 1'b0);
            end
        join

        // 4: M0 write makes M0 last served, then reset aborts an M0 read in WAIT
        access(1'b0, 1'b1, 32'h6, 32'h00000011, 32'h0, 2, 1'b1);
        @(negedge clk);
        bus.M0_REQ = 1'b1; bus.M0_WR = 1'b0; bus.M0_ADDR = 32'h3;
        sb_push(1'b0, 1'b0, 32'h3, 32'h0, 32'hCAFEBEEF, cyc, 3);
        @(negedge clk);   // strobe cycle
        @(negedge clk);   // wait cycle
        rst = 1'b1;
        bus.M0_REQ = 1'b0;
        sb.delete();
        exp_rd[0] = '0; exp_rd[1] = '0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check32("abort_no_ack", 32'({bus.M1_ACK, bus.M0_ACK}), 32'd0);
        // first post-reset tie must go to M0
        sb_push(1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678, 0, -1);
        sb_push(1'b1, 1'b0, 32'h1, 32'h0, 32'h00000050, 0, -1);
        fork
            access(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, -1, 1'b0);
            access(1'b1, 1'b0, 32'h1, 32'h0, 32'h0, -1, 1'b0);
        join

        // 5: READ_LAT = 3, ACK in cycle 5, SP_DO of cycle 4 captured
        @(negedge clk);
        bus3.M0_REQ = 1'b1; bus3.M0_WR = 1'b0; bus3.M0_ADDR = 32'h3;
        t0 = cyc;
        n  = 0;
        while (!bus3.M0_ACK && n < 60) begin
            @(negedge clk);
            n++;
            if (bus3.SP_RE) check32("lat3_re_cycle", 32'(cyc - t0), 32'd1);
        end
        bus3.M0_REQ = 1'b0;
        check32("lat3_ack_cycle", 32'(cyc - t0), 32'd5);
        check32("lat3_rdata", bus3.M0_RDATA, 32'hCAFEBEEF);
        check32("lat3_gnt", 32'(bus3.GNT), 32'd1);

        // 6: M0_LOCK held, both requesting
        bus.M0_LOCK = 1'b1;
`ifdef OPB_ARB_LOCK_EN
        sb_push(1'b0, 1'b1, 32'h8, 32'h000000A0, 32'h0, 0, -1);
        sb_push(1'b0, 1'b1, 32'h9, 32'h000000A1, 32'h0, 0, -1);
        sb_push(1'b1, 1'b1, 32'hA, 32'h000000B0, 32'h0, 0, -1);
`else
        sb_push(1'b0, 1'b1, 32'h8, 32'h000000A0, 32'h0, 0, -1);
        sb_push(1'b1, 1'b1, 32'hA, 32'h000000B0, 32'h0, 0, -1);
        sb_push(1'b0, 1'b1, 32'h9, 32'h000000A1, 32'h0, 0, -1);
`endif
        fork
            begin
                access(1'b0, 1'b1, 32'h8, 32'h000000A0, 32'h0, -1, 1'b0);
                access(1'b0, 1'b1, 32'h9, 32'h000000A1, 32'h0, -1, 1'b0);
            end
            access(1'b1, 1'b1, 32'hA, 32'h000000B0, 32'h0, -1, 1'b0);
        join
        bus.M0_LOCK = 1'b0;

        repeat (5) @(negedge clk);
        check32("idle_gnt", 32'(bus.GNT), 32'd0);
        check32("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
